buffer_rd_ctrl: RTL and testbench

- Read-side controller for the dual-clock simple dual-port buffer RAM (1-cycle registered read, gated by read enable).
- On a start command, fetches a block of ILEN words from a start address and presents them as a valid/ready stream with backpressure.
- Sits in the read clock domain: `oen_rd`, `or_addr` and `irdata` connect directly to the RAM read port, and the RAM read clock is `iclk`.

---
 rtl/buffer_rd_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_buffer_rd_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/buffer_rd_ctrl.sv
// ----------------------------------------------------------------------------
// buffer_rd_ctrl
//
// Read-side controller for the dual-clock simple dual-port buffer RAM. On a
// start command it fetches ilen words beginning at istart_addr and presents
// them as a valid/ready stream with full backpressure support. The RAM read
// port has a registered read that is gated by oen_rd, so irdata is valid the
// cycle after oen_rd and holds its value while oen_rd stays low.
//
// Ports
//   iclk         clock, also the RAM read clock
//   irst_n       asynchronous active-low reset
//   istart       start pulse, sampled only while idle
//   istart_addr  first word address, sampled with istart
//   ilen         word count 0..2**ADDR_W, sampled with istart
//   oen_rd       RAM read enable (registered)
//   or_addr      RAM read address (registered)
//   irdata       RAM read data, valid the cycle after oen_rd
//   odata        stream data
//   ovalid       stream valid
//   iready       stream ready
//   olast        marks the final word of the block
//   obusy        block transfer in progress
//   odone        one-cycle completion pulse
// ----------------------------------------------------------------------------
module buffer_rd_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 18
) (
    input  logic              iclk,
    input  logic              irst_n,
    input  logic              istart,
    input  logic [ADDR_W-1:0] istart_addr,
    input  logic [ADDR_W:0]   ilen,
    output logic              oen_rd,
    output logic [ADDR_W-1:0] or_addr,
    input  logic [DATA_W-1:0] irdata,
    output logic [DATA_W-1:0] odata,
    output logic              ovalid,
    input  logic              iready,
    output logic              olast,
    output logic              obusy,
    output logic              odone
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN
    } state_t;

    localparam logic [ADDR_W:0] LEN_ONE = 1;

    state_t            state;
    state_t            state_nxt;

    logic [ADDR_W-1:0] addr;        // next address to issue
    logic [ADDR_W:0]   rem_issue;   // reads still to issue
    logic [ADDR_W:0]   rem_out;     // words still to hand over
    logic              rd_pend;     // irdata holds a word not yet pushed

    // Two-entry skid FIFO.
    logic [DATA_W-1:0] fifo_mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        fifo_cnt;

    logic              start_blk;
    logic              issue_rd;
    logic              issue;
    logic              push;
    logic              pop;
    logic              done_nxt;
    logic [2:0]        outstanding;
    logic              credit_ok;

    assign ovalid = (fifo_cnt != 2'd0);
    assign odata  = fifo_mem[rd_ptr];
    assign olast  = ovalid && (rem_out == LEN_ONE);
    assign pop    = ovalid && iready;

    // A word sitting in the RAM output register can only move into the FIFO
    // when a slot is free, or one is freed by a pop in the same cycle.
    assign push   = rd_pend && ((fifo_cnt != 2'd2) || pop);

    // Words already committed: FIFO entries, the word parked at the RAM
    // output and the read currently in the RAM. The RAM output register is
    // the third storage slot (it holds while oen_rd is low), which lets the
    // two-entry FIFO sustain one word per clock across the three-cycle
    // issue-to-output loop without ever overflowing.
    assign outstanding = 3'(fifo_cnt) + 3'(rd_pend) + 3'(oen_rd);
    assign credit_ok   = outstanding < (3'd3 + 3'(pop));

    assign start_blk = (state == S_IDLE) && istart && (ilen != '0);
    assign issue     = start_blk || issue_rd;

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    // NOTE: sequential state always uses non-blocking (<=) so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state and outputs
    // ------------------------------------------------------------------------
    // NOTE: every signal written here is given a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        issue_rd  = 1'b0;
        obusy     = 1'b0;
        case (state)
            S_IDLE: begin
                if (istart) begin
                    if (ilen == '0) begin
                        done_nxt = 1'b1;
                    end else if (ilen == LEN_ONE) begin
                        // The only read is issued on the start edge itself.
                        state_nxt = S_DRAIN;
                    end else begin
                        state_nxt = S_READ;
                    end
                end
            end
            S_READ: begin
                obusy    = 1'b1;
                issue_rd = (rem_issue != '0) && credit_ok;
                if (issue_rd && (rem_issue == LEN_ONE)) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                obusy = 1'b1;
                if (pop && olast) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Read issue, counters and completion pulse
    // ------------------------------------------------------------------------
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            oen_rd    <= 1'b0;
            or_addr   <= '0;
            addr      <= '0;
            rem_issue <= '0;
            rem_out   <= '0;
            rd_pend   <= 1'b0;
            odone     <= 1'b0;
        end else begin
            oen_rd <= issue;
            odone  <= done_nxt;

            if (start_blk) begin
                // First read goes out directly with the start address.
                or_addr   <= istart_addr;
                addr      <= istart_addr + 1'b1;
                rem_issue <= ilen - 1'b1;
            end else if (issue_rd) begin
                or_addr   <= addr;
                addr      <= addr + 1'b1;   // wraps modulo 2**ADDR_W
                rem_issue <= rem_issue - 1'b1;
            end

            if (start_blk) begin
                rem_out <= ilen;
            end else if (pop) begin
                rem_out <= rem_out - 1'b1;
            end

            // A fresh read always lands; the credit rule guarantees the
            // previous word has been pushed by then.
            if (oen_rd) begin
                rd_pend <= 1'b1;
            end else if (push) begin
                rd_pend <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Skid FIFO
    // ------------------------------------------------------------------------
    // NOTE: the two storage words are reset along with the pointers so odata
    // reads zero out of reset; a large RAM array would be left unreset.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_cnt    <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= irdata;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_cnt <= fifo_cnt + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: tb/tb_buffer_rd_ctrl.sv
// ----------------------------------------------------------------------------
// tb_buffer_rd_ctrl
//
// Directed bench for buffer_rd_ctrl with a behavioural gated-read RAM. Each
// start pushes the expected read addresses and stream words into queues; a
// monitor pops and compares them as the DUT issues reads and hands over data.
// ----------------------------------------------------------------------------
module tb_buffer_rd_ctrl;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
    } exp_word_t;

    logic              clk = 1'b0;
    logic              irst_n;
    logic              istart;
    logic [ADDR_W-1:0] istart_addr;
    logic [ADDR_W:0]   ilen;
    logic              oen_rd;
    logic [ADDR_W-1:0] or_addr;
    logic [DATA_W-1:0] irdata = '0;
    logic [DATA_W-1:0] odata;
    logic              ovalid;
    logic              iready;
    logic              olast;
    logic              obusy;
    logic              odone;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] addr_q [$];
    exp_word_t         data_q [$];
    bit                ready_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    buffer_rd_ctrl #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .iclk        (clk),
        .irst_n      (irst_n),
        .istart      (istart),
        .istart_addr (istart_addr),
        .ilen        (ilen),
        .oen_rd      (oen_rd),
        .or_addr     (or_addr),
        .irdata      (irdata),
        .odata       (odata),
        .ovalid      (ovalid),
        .iready      (iready),
        .olast       (olast),
        .obusy       (obusy),
        .odone       (odone)
    );

    // RAM read port: registered, gated by the read enable.
    always @(posedge clk) begin
        if (oen_rd) irdata <= mem[or_addr];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_oen_rd"},  64'(oen_rd),  64'd0);
        check({tag, "_or_addr"}, 64'(or_addr), 64'd0);
        check({tag, "_odata"},   64'(odata),   64'd0);
        check({tag, "_ovalid"},  64'(ovalid),  64'd0);
        check({tag, "_olast"},   64'(olast),   64'd0);
        check({tag, "_obusy"},   64'(obusy),   64'd0);
        check({tag, "_odone"},   64'(odone),   64'd0);
    endtask

    // Drive a start for one cycle and record what the DUT must produce.
    task automatic start_block(input logic [ADDR_W-1:0] a, input logic [ADDR_W:0] len);
        exp_word_t w;
        istart      = 1'b1;
        istart_addr = a;
        ilen        = len;
        for (int i = 0; i < int'(len); i++) begin
            addr_q.push_back(ADDR_W'(int'(a) + i));
            w.data = mem[ADDR_W'(int'(a) + i)];
            w.last = (i == int'(len) - 1);
            data_q.push_back(w);
        end
        @(posedge clk); #1;
        istart = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, input bit toggle);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            if (toggle) iready = ready_pat[i % 4];
            @(negedge clk);
            if (odone) seen = 1'b1;
            @(posedge clk); #1;
        end
        iready = 1'b1;
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        check({tag, "_rd_left"},   64'(addr_q.size()), 64'd0);
        check({tag, "_data_left"}, 64'(data_q.size()), 64'd0);
        check({tag, "_idle"},      64'(obusy), 64'd0);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (irst_n) begin
            if (oen_rd) begin
                if (addr_q.size() == 0) check("rd_overfetch", 64'(oen_rd), 64'd0);
                else check("rd_addr", 64'(or_addr), 64'(addr_q.pop_front()));
            end
            if (ovalid) begin
                if (data_q.size() == 0) begin
                    check("valid_unexpected", 64'(ovalid), 64'd0);
                end else begin
                    check("odata", 64'(odata), 64'(data_q[0].data));
                    check("olast", 64'(olast), 64'(data_q[0].last));
                    if (iready) data_q.delete(0);
                end
            end
            check("fifo_occupancy_le2", 64'(dut.fifo_cnt <= 2'd2), 64'd1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        istart      = 1'b0;
        istart_addr = '0;
        ilen        = '0;
        iready      = 1'b1;
        irst_n      = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        #2;
        check_zero("reset");
        repeat (3) @(posedge clk);
        #1 irst_n = 1'b1;
        @(posedge clk); #1;

        // Basic block: cycle-exact timing.
        start_block(5'h10, 6'd4);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            check($sformatf("basic_oen_c%0d", c),    64'(oen_rd), 64'(c >= 1 && c <= 4));
            check($sformatf("basic_valid_c%0d", c),  64'(ovalid), 64'(c >= 3 && c <= 6));
            check($sformatf("basic_last_c%0d", c),   64'(olast),  64'(c == 6));
            check($sformatf("basic_done_c%0d", c),   64'(odone),  64'(c == 7));
            check($sformatf("basic_busy_c%0d", c),   64'(obusy),  64'(c >= 1 && c <= 6));
        end
        @(posedge clk); #1;
        check("basic_rd_left",   64'(addr_q.size()), 64'd0);
        check("basic_data_left", 64'(data_q.size()), 64'd0);

        // Address wrap 30,31,0,1.
        start_block(5'd30, 6'd4);
        wait_done("wrap", 50, 1'b0);

        // Backpressure with iready pattern 1,0,0,1.
        start_block(5'd4, 6'd8);
        wait_done("bp", 200, 1'b1);

        // Zero length: done next cycle, no reads, no data.
        start_block(5'd7, 6'd0);
        @(negedge clk);
        check("len0_done",   64'(odone),  64'd1);
        check("len0_oen",    64'(oen_rd), 64'd0);
        check("len0_valid",  64'(ovalid), 64'd0);
        check("len0_busy",   64'(obusy),  64'd0);
        @(negedge clk);
        check("len0_done_1cyc", 64'(odone), 64'd0);
        @(posedge clk); #1;

        // Single word.
        start_block(5'd12, 6'd1);
        wait_done("len1", 50, 1'b0);

        // Start while busy is ignored.
        start_block(5'd20, 6'd6);
        istart      = 1'b1;
        istart_addr = 5'd0;
        ilen        = 6'd5;
        @(posedge clk); #1;
        istart = 1'b0;
        wait_done("busy_start", 100, 1'b0);
        repeat (4) @(posedge clk);
        #1;

        // Reset in cycle 5 of a 16-word block.
        start_block(5'd3, 6'd16);
        repeat (4) @(posedge clk);
        #1 irst_n = 1'b0;
        #1;
        check_zero("midrst");
        addr_q.delete();
        data_q.delete();
        repeat (2) @(posedge clk);
        #1 irst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("midrst_nodone_%0d", c), 64'(odone),  64'd0);
            check($sformatf("midrst_noread_%0d", c), 64'(oen_rd), 64'd0);
        end
        @(posedge clk); #1;
        start_block(5'd7, 6'd3);
        wait_done("after_rst", 50, 1'b0);

        // Full buffer.
        start_block(5'd9, 6'd32);
        wait_done("full", 200, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
